// File: rtl/exmem_stage_reg.sv
// EX->MEM pipeline register with stall/flush priority, bubble insertion and x0 write squash.
// Define EXMEM_PERF_CNT_EN to add perf_clr and saturating stall/flush/bubble counters.
module exmem_stage_reg #(
  parameter int XLEN = 32,
  parameter int REGW = 5,
  parameter int RSW  = 2,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            reset,
`ifdef EXMEM_PERF_CNT_EN
  input  logic            perf_clr,
  output logic [CNTW-1:0] stall_cnt,
  output logic [CNTW-1:0] flush_cnt,
  output logic [CNTW-1:0] bubble_cnt,
`endif
  input  logic            stall,
  input  logic            flush,
  input  logic            ValidE,
  input  logic            RegWriteE,
  input  logic            MemWriteE,
  input  logic [RSW-1:0]  ResultSrcE,
  input  logic [REGW-1:0] rdE,
  input  logic [XLEN-1:0] PCplus4E,
  input  logic [XLEN-1:0] ALUResultE,
  input  logic [XLEN-1:0] WriteDataE,
  output logic            ValidM,
  output logic            RegWriteM,
  output logic            MemWriteM,
  output logic [RSW-1:0]  ResultSrcM,
  output logic [REGW-1:0] rdM,
  output logic [XLEN-1:0] PCplus4M,
  output logic [XLEN-1:0] ALUResultM,
  output logic [XLEN-1:0] WriteDataM
);

  logic            bubble_s;
  logic            load_s;
  logic            regwrite_s;
  logic            memwrite_s;

  logic            valid_r;
  logic            regwrite_r;
  logic            memwrite_r;
  logic [RSW-1:0]  resultsrc_r;
  logic [REGW-1:0] rd_r;
  logic [XLEN-1:0] pcplus4_r;
  logic [XLEN-1:0] aluresult_r;
  logic [XLEN-1:0] writedata_r;

  // Edge decode: flush beats stall; an invalid EX slot on a load is a bubble too.
  always_comb begin
    bubble_s   = flush | (~stall & ~ValidE);
    load_s     = ~flush & ~stall & ValidE;
    regwrite_s = RegWriteE & ValidE & (rdE != {REGW{1'b0}});
    memwrite_s = MemWriteE & ValidE;
  end

  // Pipeline state: bubble clears control fields but leaves the datapath untouched.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_r     <= 1'b0;
      regwrite_r  <= 1'b0;
      memwrite_r  <= 1'b0;
      resultsrc_r <= {RSW{1'b0}};
      rd_r        <= {REGW{1'b0}};
      pcplus4_r   <= {XLEN{1'b0}};
      aluresult_r <= {XLEN{1'b0}};
      writedata_r <= {XLEN{1'b0}};
    end else if (bubble_s) begin
      valid_r     <= 1'b0;
      regwrite_r  <= 1'b0;
      memwrite_r  <= 1'b0;
      resultsrc_r <= {RSW{1'b0}};
      rd_r        <= {REGW{1'b0}};
    end else if (load_s) begin
      valid_r     <= 1'b1;
      regwrite_r  <= regwrite_s;
      memwrite_r  <= memwrite_s;
      resultsrc_r <= ResultSrcE;
      rd_r        <= rdE;
      pcplus4_r   <= PCplus4E;
      aluresult_r <= ALUResultE;
      writedata_r <= WriteDataE;
    end else begin
      valid_r     <= valid_r;
    end
  end

  assign ValidM     = valid_r;
  assign RegWriteM  = regwrite_r;
  assign MemWriteM  = memwrite_r;
  assign ResultSrcM = resultsrc_r;
  assign rdM        = rd_r;
  assign PCplus4M   = pcplus4_r;
  assign ALUResultM = aluresult_r;
  assign WriteDataM = writedata_r;

`ifdef EXMEM_PERF_CNT_EN
  logic [CNTW-1:0] stall_cnt_r;
  logic [CNTW-1:0] flush_cnt_r;
  logic [CNTW-1:0] bubble_cnt_r;

  function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
    if (v == {CNTW{1'b1}}) begin
      return v;
    end else begin
      return v + {{(CNTW-1){1'b0}}, 1'b1};
    end
  endfunction

  // Event counters saturate rather than wrap; clear wins over any increment.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_r  <= {CNTW{1'b0}};
      flush_cnt_r  <= {CNTW{1'b0}};
      bubble_cnt_r <= {CNTW{1'b0}};
    end else if (perf_clr) begin
      stall_cnt_r  <= {CNTW{1'b0}};
      flush_cnt_r  <= {CNTW{1'b0}};
      bubble_cnt_r <= {CNTW{1'b0}};
    end else begin
      if (stall && !flush) begin
        stall_cnt_r <= sat_inc(stall_cnt_r);
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
      if (flush) begin
        flush_cnt_r <= sat_inc(flush_cnt_r);
      end else begin
        flush_cnt_r <= flush_cnt_r;
      end
      if (bubble_s) begin
        bubble_cnt_r <= sat_inc(bubble_cnt_r);
      end else begin
        bubble_cnt_r <= bubble_cnt_r;
      end
    end
  end

  assign stall_cnt  = stall_cnt_r;
  assign flush_cnt  = flush_cnt_r;
  assign bubble_cnt = bubble_cnt_r;
`endif

endmodule

// File: tb/tb_exmem_stage_reg.sv
// Directed bench for exmem_stage_reg; counter section active when EXMEM_PERF_CNT_EN is defined.
module tb_exmem_stage_reg;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall, flush, ValidE, RegWriteE, MemWriteE;
  logic [1:0]  ResultSrcE;
  logic [4:0]  rdE;
  logic [31:0] PCplus4E, ALUResultE, WriteDataE;
  logic        ValidM, RegWriteM, MemWriteM;
  logic [1:0]  ResultSrcM;
  logic [4:0]  rdM;
  logic [31:0] PCplus4M, ALUResultM, WriteDataM;
  logic        perf_clr;
  logic [3:0]  stall_cnt, flush_cnt, bubble_cnt;

  int total = 0;
  int bad   = 0;

  exmem_stage_reg #(.XLEN(32), .REGW(5), .RSW(2), .CNTW(4)) dut (
    .clk(clk), .reset(reset),
`ifdef EXMEM_PERF_CNT_EN
    .perf_clr(perf_clr), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .bubble_cnt(bubble_cnt),
`endif
    .stall(stall), .flush(flush), .ValidE(ValidE), .RegWriteE(RegWriteE),
    .MemWriteE(MemWriteE), .ResultSrcE(ResultSrcE), .rdE(rdE), .PCplus4E(PCplus4E),
    .ALUResultE(ALUResultE), .WriteDataE(WriteDataE), .ValidM(ValidM),
    .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
    .rdM(rdM), .PCplus4M(PCplus4M), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ctrl(input string tag, input logic v, input logic rw, input logic mw,
                          input logic [1:0] rs, input logic [4:0] rd);
    chk({tag, ".ValidM"}, {31'd0, ValidM}, {31'd0, v});
    chk({tag, ".RegWriteM"}, {31'd0, RegWriteM}, {31'd0, rw});
    chk({tag, ".MemWriteM"}, {31'd0, MemWriteM}, {31'd0, mw});
    chk({tag, ".ResultSrcM"}, {30'd0, ResultSrcM}, {30'd0, rs});
    chk({tag, ".rdM"}, {27'd0, rdM}, {27'd0, rd});
  endtask

  task automatic chk_data(input string tag, input logic [31:0] pc, input logic [31:0] alu,
                          input logic [31:0] wd);
    chk({tag, ".PCplus4M"}, PCplus4M, pc);
    chk({tag, ".ALUResultM"}, ALUResultM, alu);
    chk({tag, ".WriteDataM"}, WriteDataM, wd);
  endtask

  initial begin
    reset = 1'b0; stall = 1'b0; flush = 1'b0; perf_clr = 1'b0;
    ValidE = 1'b0; RegWriteE = 1'b0; MemWriteE = 1'b0; ResultSrcE = 2'd0;
    rdE = 5'd0; PCplus4E = 32'd0; ALUResultE = 32'd0; WriteDataE = 32'd0;
    #12;
    chk_ctrl("reset", 1'b0, 1'b0, 1'b0, 2'd0, 5'd0);
    chk_data("reset", 32'd0, 32'd0, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // pass-through
    ValidE = 1'b1; RegWriteE = 1'b1; MemWriteE = 1'b0; ResultSrcE = 2'd1; rdE = 5'd5;
    PCplus4E = 32'h0000_0104; ALUResultE = 32'hDEAD_BEEF; WriteDataE = 32'h1234_5678;
    tick();
    chk_ctrl("pass", 1'b1, 1'b1, 1'b0, 2'd1, 5'd5);
    chk_data("pass", 32'h0000_0104, 32'hDEAD_BEEF, 32'h1234_5678);

    // x0 squash
    rdE = 5'd0; MemWriteE = 1'b1; ALUResultE = 32'hCAFE_F00D; PCplus4E = 32'h0000_0108;
    tick();
    chk_ctrl("x0", 1'b1, 1'b0, 1'b1, 2'd1, 5'd0);
    chk_data("x0", 32'h0000_0108, 32'hCAFE_F00D, 32'h1234_5678);

    // stall holds for 3 edges
    stall = 1'b1; rdE = 5'd7; ALUResultE = 32'h1111_1111; ResultSrcE = 2'd2;
    PCplus4E = 32'h0000_0200; WriteDataE = 32'h5555_5555;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_ctrl("stall", 1'b1, 1'b0, 1'b1, 2'd1, 5'd0);
      chk_data("stall", 32'h0000_0108, 32'hCAFE_F00D, 32'h1234_5678);
    end

    // stall + flush -> bubble, datapath held
    flush = 1'b1;
    tick();
    chk_ctrl("stall_flush", 1'b0, 1'b0, 1'b0, 2'd0, 5'd0);
    chk_data("stall_flush", 32'h0000_0108, 32'hCAFE_F00D, 32'h1234_5678);

    // plain load after flush
    stall = 1'b0; flush = 1'b0;
    tick();
    chk_ctrl("reload", 1'b1, 1'b1, 1'b1, 2'd2, 5'd7);
    chk_data("reload", 32'h0000_0200, 32'h1111_1111, 32'h5555_5555);

    // ValidE=0 load behaves as a bubble
    ValidE = 1'b0; ALUResultE = 32'h2222_2222; rdE = 5'd9;
    tick();
    chk_ctrl("invalid", 1'b0, 1'b0, 1'b0, 2'd0, 5'd0);
    chk_data("invalid", 32'h0000_0200, 32'h1111_1111, 32'h5555_5555);

    // flush alone
    ValidE = 1'b1; ALUResultE = 32'h3333_3333; rdE = 5'd3; ResultSrcE = 2'd3;
    tick();
    chk_ctrl("load3", 1'b1, 1'b1, 1'b1, 2'd3, 5'd3);
    flush = 1'b1; ALUResultE = 32'h4444_4444;
    tick();
    chk_ctrl("flush", 1'b0, 1'b0, 1'b0, 2'd0, 5'd0);
    chk("flush.ALUResultM", ALUResultM, 32'h3333_3333);

    // reset mid-stream, asynchronous
    flush = 1'b0;
    tick();
    chk_ctrl("pre_rst", 1'b1, 1'b1, 1'b1, 2'd3, 5'd3);
    #2 reset = 1'b0;
    #1;
    chk_ctrl("async_rst", 1'b0, 1'b0, 1'b0, 2'd0, 5'd0);
    chk_data("async_rst", 32'd0, 32'd0, 32'd0);

`ifdef EXMEM_PERF_CNT_EN
    @(negedge clk);
    reset = 1'b1;
    stall = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    chk("cnt.stall_sat", {28'd0, stall_cnt}, 32'd15);
    chk("cnt.flush0", {28'd0, flush_cnt}, 32'd0);
    chk("cnt.bubble0", {28'd0, bubble_cnt}, 32'd0);
    perf_clr = 1'b1;
    tick();
    chk("cnt.clr", {28'd0, stall_cnt}, 32'd0);
    perf_clr = 1'b0; stall = 1'b0; flush = 1'b1;
    tick(); tick();
    chk("cnt.flush2", {28'd0, flush_cnt}, 32'd2);
    chk("cnt.bubble2", {28'd0, bubble_cnt}, 32'd2);
    stall = 1'b1;
    tick();
    chk("cnt.sf_stall", {28'd0, stall_cnt}, 32'd0);
    chk("cnt.sf_flush", {28'd0, flush_cnt}, 32'd3);
    stall = 1'b0; flush = 1'b0; ValidE = 1'b0;
    tick();
    chk("cnt.inv_bubble", {28'd0, bubble_cnt}, 32'd4);
    chk("cnt.inv_flush", {28'd0, flush_cnt}, 32'd3);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
